// File: rtl/shared_port_arbiter.sv
// rtl/shared_port_arbiter.sv - round-robin sequencer sharing one synchronous memory port
//
// Purpose: grants one of REQ_COUNT requesters at a time in round-robin order,
// checks the granted address against [ADDR_BASE, ADDR_BOUND], rebases it to a
// port-local offset, drives a single read or write strobe, waits the port's
// fixed read latency and returns a one-hot completion pulse. Out-of-range
// requests complete with an error response and never touch the port.
//
// Ports:
//   clock_i      clock, all logic on rising edge
//   reset_i      asynchronous active-high reset
//   req_valid_i  per-requester request pending
//   req_ready_o  one-hot grant, combinational, only while idle
//   req_write_i  per-requester direction (1 = write)
//   req_addr_i   packed requester addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata_i  packed requester write data, same packing
//   rsp_valid_o  one-hot one-cycle completion pulse
//   rsp_error_o  qualifies rsp_valid_o: address was out of range
//   rsp_rdata_o  read data, valid with rsp_valid_o (0 for writes and errors)
//   mem_rden_o   port read strobe
//   mem_wren_o   port write strobe
//   mem_addr_o   port-local address (request address minus ADDR_BASE)
//   mem_wdata_o  port write data
//   mem_rdata_i  port read data, RD_LATENCY cycles after the read strobe
module shared_port_arbiter #(
  parameter int REQ_COUNT  = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_BASE  = 0,
  parameter int ADDR_BOUND = 1023,
  parameter int RD_LATENCY = 2
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic [REQ_COUNT-1:0]            req_valid_i,
  output logic [REQ_COUNT-1:0]            req_ready_o,
  input  logic [REQ_COUNT-1:0]            req_write_i,
  input  logic [REQ_COUNT*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [REQ_COUNT*DATA_WIDTH-1:0] req_wdata_i,
  output logic [REQ_COUNT-1:0]            rsp_valid_o,
  output logic                            rsp_error_o,
  output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                            mem_rden_o,
  output logic                            mem_wren_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0]           mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]           mem_rdata_i
);

  localparam int IDX_W = $clog2(REQ_COUNT);
  localparam int CNT_W = $clog2(RD_LATENCY) + 1;

  // Range bounds held as signed values two bits wider than the address so
  // the comparison stays meaningful even when a bound sits at the edge of
  // the address space.
  localparam logic signed [ADDR_WIDTH+1:0] BASE_S  = (ADDR_WIDTH+2)'(ADDR_BASE);
  localparam logic signed [ADDR_WIDTH+1:0] BOUND_S = (ADDR_WIDTH+2)'(ADDR_BOUND);
  localparam logic [ADDR_WIDTH-1:0]        BASE_A  = ADDR_WIDTH'(ADDR_BASE);
  localparam logic [IDX_W-1:0]             LAST_IDX = IDX_W'(REQ_COUNT - 1);
  localparam logic [CNT_W-1:0]             CNT_INIT = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        rr_ptr_q;
  logic [IDX_W-1:0]        gnt_q;
  logic                    write_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [REQ_COUNT-1:0]    rsp_valid_q;
  logic                    rsp_error_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    mem_rden_q;
  logic                    mem_wren_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;

  logic [ADDR_WIDTH-1:0]   addr_arr  [REQ_COUNT];
  logic [DATA_WIDTH-1:0]   wdata_arr [REQ_COUNT];

  logic                    gnt_found_d;
  logic [IDX_W-1:0]        gnt_d;
  logic [ADDR_WIDTH-1:0]   sel_addr_d;
  logic [DATA_WIDTH-1:0]   sel_wdata_d;
  logic                    sel_write_d;
  logic                    in_range_d;
  logic signed [ADDR_WIDTH+1:0] sel_addr_s;

  for (genvar i = 0; i < REQ_COUNT; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [REQ_COUNT-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [REQ_COUNT-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Round-robin search: first pending requester starting at rr_ptr_q.
  always_comb begin : grant_search
    int               cand_int;
    logic [IDX_W-1:0] cand;
    gnt_found_d = 1'b0;
    gnt_d       = '0;
    cand_int    = 0;
    cand        = '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      cand_int = int'(rr_ptr_q) + k;
      if (cand_int >= REQ_COUNT) begin
        cand_int = cand_int - REQ_COUNT;
      end
      cand = IDX_W'(cand_int);
      if (!gnt_found_d && req_valid_i[cand]) begin
        gnt_found_d = 1'b1;
        gnt_d       = cand;
      end
    end
  end

  always_comb begin
    sel_addr_d  = addr_arr[gnt_d];
    sel_wdata_d = wdata_arr[gnt_d];
    sel_write_d = req_write_i[gnt_d];
    sel_addr_s  = $signed({2'b00, sel_addr_d});
    in_range_d  = (sel_addr_s >= BASE_S) && (sel_addr_s <= BOUND_S);
  end

  // Grant is the only combinational output; it is forced low while reset is
  // asserted so every output reads zero during reset.
  always_comb begin
    req_ready_o = '0;
    if (state_q == S_IDLE && gnt_found_d && !reset_i) begin
      req_ready_o = onehot(gnt_d);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_rden_q  <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Strobes and response are single-cycle pulses; they are raised on the
      // edge that enters the state in which they must be visible.
      mem_rden_q  <= 1'b0;
      mem_wren_q  <= 1'b0;
      rsp_valid_q <= '0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (gnt_found_d) begin
            gnt_q   <= gnt_d;
            write_q <= sel_write_d;
            if (in_range_d) begin
              state_q    <= S_ACCESS;
              mem_addr_q <= sel_addr_d - BASE_A;
              if (sel_write_d) begin
                mem_wren_q  <= 1'b1;
                mem_wdata_q <= sel_wdata_d;
              end else begin
                mem_rden_q  <= 1'b1;
              end
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= onehot(gnt_d);
              rsp_error_q <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          if (write_q) begin
            state_q     <= S_RESP;
            rsp_valid_q <= onehot(gnt_q);
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= CNT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= S_RESP;
            rsp_valid_q <= onehot(gnt_q);
            rsp_rdata_q <= mem_rdata_i;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q  <= S_IDLE;
          rr_ptr_q <= (gnt_q == LAST_IDX) ? '0 : gnt_q + IDX_W'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_error_o = rsp_error_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign mem_rden_o  = mem_rden_q;
  assign mem_wren_o  = mem_wren_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_shared_port_arbiter.sv
// tb/tb_shared_port_arbiter.sv - self-checking bench for shared_port_arbiter
module tb_shared_port_arbiter;

  localparam int RC    = 4;
  localparam int AW    = 10;
  localparam int DW    = 36;
  localparam int BASE  = 16;
  localparam int BOUND = 31;
  localparam int RDL   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [RC-1:0]    req_valid = '0;
  logic [RC-1:0]    req_ready;
  logic [RC-1:0]    req_write = '0;
  logic [RC*AW-1:0] req_addr  = '0;
  logic [RC*DW-1:0] req_wdata = '0;
  logic [RC-1:0]    rsp_valid;
  logic             rsp_error;
  logic [DW-1:0]    rsp_rdata;
  logic             mem_rden;
  logic             mem_wren;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;

  shared_port_arbiter #(
    .REQ_COUNT(RC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ADDR_BASE(BASE), .ADDR_BOUND(BOUND), .RD_LATENCY(RDL)
  ) dut (
    .clock_i(clk), .reset_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_error_o(rsp_error), .rsp_rdata_o(rsp_rdata),
    .mem_rden_o(mem_rden), .mem_wren_o(mem_wren), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [DW-1:0] patt(input int i);
    return DW'(i) * 36'h1_0000_1003 ^ 36'h5_A5A5_0000;
  endfunction

  // Memory port: a plain array plus a RDL-deep delay line; outside the
  // valid-data cycle the read bus carries junk so late/early capture shows.
  logic [DW-1:0] port_mem [1024];
  bit            mem_inited = 1'b0;
  logic [DW-1:0] pipe_d [RDL];
  logic          pipe_v [RDL];
  logic [DW-1:0] junk = '0;

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 1024; i++) port_mem[i] = patt(i + BASE);
      mem_inited = 1'b1;
    end else if (mem_wren) begin
      port_mem[mem_addr] = mem_wdata;
    end
  end

  always @(posedge clk) begin
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    junk      <= r[DW-1:0];
    pipe_v[0] <= mem_rden;
    pipe_d[0] <= port_mem[mem_addr];
    for (int i = 1; i < RDL; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign mem_rdata = (pipe_v[RDL-1] === 1'b1) ? pipe_d[RDL-1] : junk;

  // Reference state: expected round-robin pointer and expected contents of
  // the mapped window.
  int            checks  = 0;
  int            errors  = 0;
  int            exp_ptr = 0;
  logic [DW-1:0] ref_mem [BOUND-BASE+1];
  logic          t_write [RC];
  logic [AW-1:0] t_addr  [RC];
  logic [DW-1:0] t_wdata [RC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RC-1:0] oh(input int g);
    logic [RC-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic int model_grant(input logic [RC-1:0] vec);
    for (int k = 0; k < RC; k++) begin
      if (vec[(exp_ptr + k) % RC]) return (exp_ptr + k) % RC;
    end
    return -1;
  endfunction

  task automatic pack();
    for (int i = 0; i < RC; i++) begin
      req_write[i]           = t_write[i];
      req_addr[i*AW +: AW]   = t_addr[i];
      req_wdata[i*DW +: DW]  = t_wdata[i];
    end
  endtask

  // One transaction from the idle cycle to its response cycle, checking
  // every cycle in between against the expected latency for its kind.
  task automatic txn(input logic [RC-1:0] vec, input bit keep, output int g);
    int            lat;
    int            a;
    bit            wr;
    bit            inr;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    pack();
    req_valid = vec;
    g = model_grant(vec);
    #1;
    chk("grant", 64'(req_ready), 64'(oh(g)));
    if (g < 0) return;
    wr    = t_write[g];
    a     = int'(t_addr[g]);
    inr   = (a >= BASE) && (a <= BOUND);
    lat   = !inr ? 1 : (wr ? 2 : 2 + RDL);
    exp_d = '0;
    if (inr && !wr) exp_d = ref_mem[a - BASE];
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1 && !keep) req_valid[g] = 1'b0;
      #1;
      chk("ready_busy", 64'(req_ready), 64'(0));
      chk("rden", 64'(mem_rden), 64'(inr && !wr && k == 1));
      chk("wren", 64'(mem_wren), 64'(inr && wr && k == 1));
      if (inr && k == 1) chk("mem_addr", 64'(mem_addr), 64'(a - BASE));
      if (inr && wr && k == 1) chk("mem_wdata", 64'(mem_wdata), 64'(t_wdata[g]));
      chk("rsp_valid", 64'(rsp_valid), (k == lat) ? 64'(oh(g)) : 64'(0));
      if (k == lat) begin
        chk("rsp_error", 64'(rsp_error), 64'(!inr));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_d));
      end
    end
    if (inr && wr) ref_mem[a - BASE] = t_wdata[g];
    exp_ptr = (g + 1) % RC;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_error"}, 64'(rsp_error), 64'(0));
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
    chk({tag, "_rden"}, 64'(mem_rden), 64'(0));
    chk({tag, "_wren"}, 64'(mem_wren), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
  endtask

  initial begin
    int g;
    for (int i = 0; i <= BOUND - BASE; i++) ref_mem[i] = patt(i + BASE);
    for (int i = 0; i < RC; i++) begin
      t_write[i] = 1'b0; t_addr[i] = '0; t_wdata[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Idle: nothing requested for 10 cycles
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("idle_ready", 64'(req_ready), 64'(0));
      chk("idle_rden", 64'(mem_rden), 64'(0));
      chk("idle_wren", 64'(mem_wren), 64'(0));
      chk("idle_rsp", 64'(rsp_valid), 64'(0));
    end

    // Single read: requester 0, port offset 5
    t_write[0] = 1'b0; t_addr[0] = AW'(BASE + 5);
    txn(4'b0001, 1'b0, g);

    // Range edges
    t_write[1] = 1'b0; t_addr[1] = AW'(15);
    txn(4'b0010, 1'b0, g);
    t_write[2] = 1'b0; t_addr[2] = AW'(16);
    txn(4'b0100, 1'b0, g);
    t_write[3] = 1'b0; t_addr[3] = AW'(31);
    txn(4'b1000, 1'b0, g);
    t_write[0] = 1'b0; t_addr[0] = AW'(32);
    txn(4'b0001, 1'b0, g);

    // Write then read-back
    t_write[2] = 1'b1; t_addr[2] = AW'(20); t_wdata[2] = 36'h1_2345_6789;
    txn(4'b0100, 1'b0, g);
    t_write[3] = 1'b0; t_addr[3] = AW'(20);
    txn(4'b1000, 1'b0, g);

    // Fairness: all four held valid across five grants
    for (int i = 0; i < RC; i++) begin
      t_write[i] = 1'b0; t_addr[i] = AW'(BASE + 3 * i);
    end
    for (int n = 0; n < 5; n++) txn(4'b1111, 1'b1, g);
    req_valid = '0;

    // Randomised traffic; pending requesters keep their request unchanged
    for (int n = 0; n < 40; n++) begin
      logic [RC-1:0] vec;
      logic [63:0]   r;
      for (int i = 0; i < RC; i++) begin
        if (!req_valid[i]) begin
          r = {$urandom(), $urandom()};
          t_write[i] = r[40];
          t_addr[i]  = AW'($urandom_range(8, 40));
          t_wdata[i] = r[DW-1:0];
        end
      end
      vec = req_valid | RC'($urandom_range(0, 15));
      if (vec == '0) vec = 4'b0001;
      txn(vec, 1'b0, g);
    end
    for (int n = 0; n < RC && req_valid != '0; n++) txn(req_valid, 1'b0, g);
    req_valid = '0;

    // Reset in the middle of a read's wait phase
    t_write[2] = 1'b0; t_addr[2] = AW'(25);
    txn(4'b0100, 1'b0, g);
    t_write[1] = 1'b0; t_addr[1] = AW'(18);
    @(negedge clk);
    pack();
    req_valid = 4'b0010;
    #1;
    chk("rstw_grant", 64'(req_ready), 64'(oh(model_grant(4'b0010))));
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("rstw_rden", 64'(mem_rden), 64'(1));
    @(negedge clk);
    #1;
    chk("rstw_wait_rsp", 64'(rsp_valid), 64'(0));
    rst = 1'b1;
    #1;
    chk_all_zero("rstw");
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rstw_hold_rsp", 64'(rsp_valid), 64'(0));
      chk("rstw_hold_rden", 64'(mem_rden), 64'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    exp_ptr = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("post_rst_rsp", 64'(rsp_valid), 64'(0));
      chk("post_rst_strobe", 64'(mem_rden | mem_wren), 64'(0));
    end
    for (int i = 0; i < RC; i++) begin
      t_write[i] = 1'b0; t_addr[i] = AW'(BASE + 2 * i);
    end
    txn(4'b1111, 1'b0, g);
    req_valid = '0;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
